trap_ctrl: RTL and testbench

Machine-mode trap controller driving the interrupt side of the CSR register file. Owns the machine timer (mtime/mtimecmp), synchronises the external interrupt line and arbitrates pending interrupts against mstatus.MIE/mie. It issues the one-cycle `intr_expc` strobe to the CSR file, so PC_MW is captured as mepc. It also sequences the pipeline flush and PC redirect for trap entry and `mret` return. Sits beside the CSR file at the MW (memory/writeback) stage of the 3-stage pipeline.

---
 rtl/trap_pkg.sv | 22 ++
 rtl/trap_ctrl_machine_timer.sv | 77 +++++++
 rtl/trap_ctrl.sv | 122 ++++++++++++
 tb/tb_trap_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/trap_pkg.sv
// Shared definitions for the machine-mode trap controller.
//   state_e        : trap FSM states
//   CAUSE_*        : mcause values for the two interrupt sources
//   TMR_ADDR_*     : word addresses of the memory-mapped timer registers
package trap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TRAP    = 2'd1,
        ST_HANDLER = 2'd2,
        ST_RETURN  = 2'd3
    } state_e;

    localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
    localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

    localparam logic [1:0] TMR_ADDR_CMP_LO  = 2'd0;
    localparam logic [1:0] TMR_ADDR_CMP_HI  = 2'd1;
    localparam logic [1:0] TMR_ADDR_TIME_LO = 2'd2;
    localparam logic [1:0] TMR_ADDR_TIME_HI = 2'd3;

endpackage

// File: rtl/trap_ctrl_machine_timer.sv
// Machine timer: prescaled 64-bit mtime, 64-bit mtimecmp, registered compare.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   tmr_wr/addr/wdata     : register write port from the LSU
//   tmr_rdata             : combinational read of the register at tmr_addr
//   mip_mtip              : registered (mtime >= mtimecmp)
module machine_timer
    import trap_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tmr_wr,
    input  logic [1:0]  tmr_addr,
    input  logic [31:0] tmr_wdata,
    output logic [31:0] tmr_rdata,
    output logic        mip_mtip
);

    localparam logic [31:0] PRESC_MAX = 32'(TICK_DIV - 1);

    logic [31:0] presc_q, presc_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        mtip_q, mtip_d;
    logic        tick_s;

    // Next-state for prescaler, mtime and mtimecmp; writes to mtime beat the tick.
    always_comb begin
        tick_s     = (presc_q == PRESC_MAX);
        presc_d    = tick_s ? 32'd0 : presc_q + 32'd1;
        mtime_d    = tick_s ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        mtip_d     = (mtime_q >= mtimecmp_q);
        if (tmr_wr) begin
            case (tmr_addr)
                TMR_ADDR_CMP_LO:  mtimecmp_d = {mtimecmp_q[63:32], tmr_wdata};
                TMR_ADDR_CMP_HI:  mtimecmp_d = {tmr_wdata, mtimecmp_q[31:0]};
                TMR_ADDR_TIME_LO: mtime_d    = {mtime_q[63:32], tmr_wdata};
                TMR_ADDR_TIME_HI: mtime_d    = {tmr_wdata, mtime_q[31:0]};
                default:          mtimecmp_d = mtimecmp_q;
            endcase
        end else begin
            mtimecmp_d = mtimecmp_q;
        end
    end

    // Timer state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q    <= 32'd0;
            mtime_q    <= 64'd0;
            mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
            mtip_q     <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            mtip_q     <= mtip_d;
        end
    end

    // Read mux over the four timer words.
    always_comb begin
        case (tmr_addr)
            TMR_ADDR_CMP_LO:  tmr_rdata = mtimecmp_q[31:0];
            TMR_ADDR_CMP_HI:  tmr_rdata = mtimecmp_q[63:32];
            TMR_ADDR_TIME_LO: tmr_rdata = mtime_q[31:0];
            TMR_ADDR_TIME_HI: tmr_rdata = mtime_q[63:32];
            default:          tmr_rdata = 32'd0;
        endcase
    end

    assign mip_mtip = mtip_q;

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: external-interrupt synchroniser, interrupt
// arbitration and the trap-entry / mret-return sequencing FSM.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   ext_irq                         : asynchronous level external interrupt
//   mstatus_mie, mie_mtie, mie_meie : enables from the CSR file
//   valid_MW, is_mret_MW            : MW-stage instruction qualifiers
//   tmr_*                           : timer register port
//   intr_expc, mcause               : trap capture strobe and cause to CSR file
//   mip_mtip, mip_meip              : pending mirrors for mip
//   flush, epc_sel                  : pipeline kill and PC redirect
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ext_irq,
    input  logic        mstatus_mie,
    input  logic        mie_mtie,
    input  logic        mie_meie,
    input  logic        valid_MW,
    input  logic        is_mret_MW,
    input  logic        tmr_wr,
    input  logic [1:0]  tmr_addr,
    input  logic [31:0] tmr_wdata,
    output logic [31:0] tmr_rdata,
    output logic        intr_expc,
    output logic [31:0] mcause,
    output logic        mip_mtip,
    output logic        mip_meip,
    output logic        flush,
    output logic        epc_sel
);

    logic        sync1_q, meip_q;
    state_e      state_q, state_d;
    logic [31:0] mcause_q, mcause_d;
    logic        intr_expc_q, flush_q, epc_sel_q;
    logic        ext_pend_s, tmr_pend_s, take_s, mret_s;

    machine_timer #(.TICK_DIV(TICK_DIV)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .tmr_wr    (tmr_wr),
        .tmr_addr  (tmr_addr),
        .tmr_wdata (tmr_wdata),
        .tmr_rdata (tmr_rdata),
        .mip_mtip  (mip_mtip)
    );

    // Two-flop synchroniser for the asynchronous external interrupt line.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            meip_q  <= 1'b0;
        end else begin
            sync1_q <= ext_irq;
            meip_q  <= sync1_q;
        end
    end

    assign ext_pend_s = meip_q & mie_meie;
    assign tmr_pend_s = mip_mtip & mie_mtie;
    // Bubbles never trap, so mepc always captures a real instruction.
    assign take_s     = valid_MW & mstatus_mie & (ext_pend_s | tmr_pend_s);
    assign mret_s     = valid_MW & is_mret_MW;

    // FSM next state; in IDLE an interrupt outranks a simultaneous mret.
    always_comb begin
        state_d  = state_q;
        mcause_d = mcause_q;
        case (state_q)
            ST_IDLE: begin
                if (take_s) begin
                    state_d  = ST_TRAP;
                    mcause_d = ext_pend_s ? CAUSE_MEI : CAUSE_MTI;
                end else if (mret_s) begin
                    state_d = ST_RETURN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_TRAP:    state_d = ST_HANDLER;
            ST_HANDLER: begin
                if (mret_s) begin
                    state_d = ST_RETURN;
                end else begin
                    state_d = ST_HANDLER;
                end
            end
            ST_RETURN:  state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM state and strobes; strobes are decoded from the next state so they
    // are high exactly during the TRAP / RETURN cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mcause_q    <= 32'd0;
            intr_expc_q <= 1'b0;
            flush_q     <= 1'b0;
            epc_sel_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcause_q    <= mcause_d;
            intr_expc_q <= (state_d == ST_TRAP);
            flush_q     <= (state_d == ST_TRAP) || (state_d == ST_RETURN);
            epc_sel_q   <= (state_d == ST_TRAP) || (state_d == ST_RETURN);
        end
    end

    assign mip_meip  = meip_q;
    assign mcause    = mcause_q;
    assign intr_expc = intr_expc_q;
    assign flush     = flush_q;
    assign epc_sel   = epc_sel_q;

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

    localparam int unsigned TICK = 2;

    logic        clk = 1'b0;
    logic        reset, ext_irq, mstatus_mie, mie_mtie, mie_meie;
    logic        valid_MW, is_mret_MW, tmr_wr;
    logic [1:0]  tmr_addr;
    logic [31:0] tmr_wdata, tmr_rdata, mcause;
    logic        intr_expc, mip_mtip, mip_meip, flush, epc_sel;

    trap_ctrl #(.TICK_DIV(TICK)) dut (
        .clk(clk), .reset(reset), .ext_irq(ext_irq), .mstatus_mie(mstatus_mie),
        .mie_mtie(mie_mtie), .mie_meie(mie_meie), .valid_MW(valid_MW),
        .is_mret_MW(is_mret_MW), .tmr_wr(tmr_wr), .tmr_addr(tmr_addr),
        .tmr_wdata(tmr_wdata), .tmr_rdata(tmr_rdata), .intr_expc(intr_expc),
        .mcause(mcause), .mip_mtip(mip_mtip), .mip_meip(mip_meip),
        .flush(flush), .epc_sel(epc_sel)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        flush;
        logic        intr;
        logic        epc;
        logic [31:0] cause;
        logic        mtip;
        logic        meip;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Reference model: timer as plain 64-bit arithmetic, trap handling as
    // "are we inside a handler" plus one-cycle pulse flags.
    longint unsigned m_mtime, m_cmp;
    int unsigned     m_presc;
    bit              m_sync1, m_meip, m_mtip;
    bit              m_pulse_trap, m_pulse_ret, m_in_handler;
    logic [31:0]     m_cause;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return m_cmp[31:0];
            2'd1:    return m_cmp[63:32];
            2'd2:    return m_mtime[31:0];
            default: return m_mtime[63:32];
        endcase
    endfunction

    // Advance the model across the coming clock edge and queue its outputs.
    task automatic model_step();
        exp_t e;
        bit ext_p, tmr_p, tick, n_mtip, n_meip, busy;
        longint unsigned n_mtime;
        if (reset) begin
            m_mtime = 0; m_presc = 0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF;
            m_sync1 = 0; m_meip = 0; m_mtip = 0;
            m_pulse_trap = 0; m_pulse_ret = 0; m_in_handler = 0; m_cause = 32'd0;
        end else begin
            ext_p   = m_meip & mie_meie;
            tmr_p   = m_mtip & mie_mtie;
            n_mtip  = (m_mtime >= m_cmp);
            tick    = (m_presc == TICK - 1);
            n_mtime = m_mtime + (tick ? 64'd1 : 64'd0);
            m_presc = tick ? 0 : m_presc + 1;
            if (tmr_wr) begin
                case (tmr_addr)
                    2'd0: m_cmp[31:0]  = tmr_wdata;
                    2'd1: m_cmp[63:32] = tmr_wdata;
                    2'd2: n_mtime = {m_mtime[63:32], tmr_wdata};
                    default: n_mtime = {tmr_wdata, m_mtime[31:0]};
                endcase
            end
            n_meip  = m_sync1;
            m_sync1 = ext_irq;
            // A trap pulse leads into the handler; a return pulse leaves it.
            busy = m_pulse_trap | m_pulse_ret;
            if (m_pulse_trap) begin
                m_pulse_trap = 0; m_in_handler = 1;
            end else if (m_pulse_ret) begin
                m_pulse_ret = 0; m_in_handler = 0;
            end
            if (!busy) begin
                if (!m_in_handler && valid_MW && mstatus_mie && (ext_p || tmr_p)) begin
                    m_pulse_trap = 1;
                    m_cause = ext_p ? 32'h8000_000B : 32'h8000_0007;
                end else if (valid_MW && is_mret_MW) begin
                    m_pulse_ret = 1;
                end
            end
            m_mtime = n_mtime; m_mtip = n_mtip; m_meip = n_meip;
        end
        e.flush = m_pulse_trap | m_pulse_ret;
        e.intr  = m_pulse_trap;
        e.epc   = m_pulse_trap | m_pulse_ret;
        e.cause = m_cause;
        e.mtip  = m_mtip;
        e.meip  = m_meip;
        e.rdata = m_read(tmr_addr);
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        model_step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        tmr_wr = 1'b1; tmr_addr = a; tmr_wdata = d;
        cyc();
        tmr_wr = 1'b0;
    endtask

    // Monitor: compare DUT outputs just after each edge against queued expectations.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("flush",     flush,     e.flush);
                chk("intr_expc", intr_expc, e.intr);
                chk("epc_sel",   epc_sel,   e.epc);
                chk("mcause",    mcause,    e.cause);
                chk("mip_mtip",  mip_mtip,  e.mtip);
                chk("mip_meip",  mip_meip,  e.meip);
                chk("tmr_rdata", tmr_rdata, e.rdata);
            end
        end
    end

    initial begin
        int guard;
        reset = 1'b1; ext_irq = 1'b0; mstatus_mie = 1'b0; mie_mtie = 1'b0;
        mie_meie = 1'b0; valid_MW = 1'b0; is_mret_MW = 1'b0; tmr_wr = 1'b0;
        tmr_addr = 2'd2; tmr_wdata = 32'd0;
        @(negedge clk);
        cyc(); cyc();
        reset = 1'b0;

        // Idle: mtime counts, nothing pending.
        repeat (20) cyc();

        // Timer interrupt at mtime == 30, then an mret to return.
        wr(2'd0, 32'd30);
        wr(2'd1, 32'd0);
        mstatus_mie = 1'b1; mie_mtie = 1'b1; valid_MW = 1'b1;
        repeat (40) cyc();
        is_mret_MW = 1'b1; cyc(); is_mret_MW = 1'b0;

        // External and timer together: external wins.
        mie_meie = 1'b1; ext_irq = 1'b1;
        repeat (8) cyc();
        is_mret_MW = 1'b1; cyc(); is_mret_MW = 1'b0;

        // Pending with bubbles only, then a real instruction.
        valid_MW = 1'b0;
        repeat (6) cyc();
        valid_MW = 1'b1;
        repeat (3) cyc();
        is_mret_MW = 1'b1; cyc(); is_mret_MW = 1'b0;
        ext_irq = 1'b0; mstatus_mie = 1'b0;

        // 64-bit wrap, then a low-word write landing on a tick.
        wr(2'd3, 32'hFFFF_FFFF);
        wr(2'd2, 32'hFFFF_FFF0);
        tmr_addr = 2'd3;
        repeat (40) cyc();
        guard = 0;
        while (m_presc != TICK - 1 && guard < 10) begin cyc(); guard++; end
        wr(2'd2, 32'd5);
        tmr_addr = 2'd2;
        cyc();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 499) == 0);
            ext_irq     = ($urandom_range(0, 19) == 0) ? ~ext_irq : ext_irq;
            mstatus_mie = ($urandom_range(0, 9) != 0);
            mie_mtie    = ($urandom_range(0, 4) != 0);
            mie_meie    = ($urandom_range(0, 4) != 0);
            valid_MW    = ($urandom_range(0, 4) != 0);
            is_mret_MW  = ($urandom_range(0, 7) == 0);
            tmr_addr    = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 14) == 0) begin
                tmr_wr = 1'b1;
                case ($urandom_range(0, 3))
                    0: begin tmr_addr = 2'd0; tmr_wdata = m_mtime[31:0] + $urandom_range(0, 40); end
                    1: begin tmr_addr = 2'd1; tmr_wdata = m_mtime[63:32]; end
                    2: begin tmr_addr = 2'd1; tmr_wdata = 32'hFFFF_FFFF; end
                    default: begin tmr_addr = 2'd2; tmr_wdata = $urandom_range(0, 200); end
                endcase
            end else begin
                tmr_wr = 1'b0;
            end
            cyc();
        end
        reset = 1'b0; tmr_wr = 1'b0;

        // Reset while the DUT sits in a trap cycle.
        mstatus_mie = 1'b1; mie_mtie = 1'b1; valid_MW = 1'b1; is_mret_MW = 1'b0;
        wr(2'd0, 32'd0);
        wr(2'd1, 32'd0);
        guard = 0;
        while (!m_pulse_trap && guard < 200) begin
            is_mret_MW = ($urandom_range(0, 3) == 0);
            cyc(); guard++;
        end
        chk("reached_trap", m_pulse_trap, 1'b1);
        reset = 1'b1; tmr_addr = 2'd0;
        cyc();
        reset = 1'b0; mstatus_mie = 1'b0; is_mret_MW = 1'b0;
        repeat (4) cyc();

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
